add_accum: RTL

Streaming frame accumulator that sums a fixed count of operand samples into a minimal-width result. It sits directly upstream of the adder reduction flow: its single accumulate `+` is sized exactly A_WIDTH+clog2(COUNT), so synthesis never sees an oversized `$add`. Operands enter over a valid/ready handshake, and one sum per frame leaves over a second valid/ready handshake.

---
 rtl/add_accum_pkg.sv | 28 ++
 rtl/add_accum.sv | 124 ++++++++++++
 2 files changed

// File: rtl/add_accum_pkg.sv
// Shared types and helpers for the frame accumulator.
package add_accum_pkg;

  // Widest sample the extension helper handles.
  localparam int EXT_W = 64;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Extend the low w bits of v to EXT_W bits: sign-extend when s=1,
  // zero-extend when s=0. Callers truncate the result to their width.
  function automatic logic [EXT_W-1:0] ext(
    input logic [EXT_W-1:0] v,
    input int unsigned      w,
    input logic             s
  );
    logic [5:0]       msb_idx;
    logic             fill;
    logic [EXT_W-1:0] mask;
    msb_idx = 6'(w - 32'd1);
    fill    = s & v[msb_idx];
    mask    = ~({EXT_W{1'b1}} << w);
    return (v & mask) | ({EXT_W{fill}} & ~mask);
  endfunction

endpackage

// File: rtl/add_accum.sv
// Streaming frame accumulator: sums COUNT samples into an exact-width result
// with valid/ready handshakes on both sides and a single Y_WIDTH adder.
module add_accum
  import add_accum_pkg::*;
#(
  parameter  int A_WIDTH  = 8,
  parameter  int A_SIGNED = 0,
  parameter  int COUNT    = 4,
  localparam int Y_WIDTH  = A_WIDTH + $clog2(COUNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] out_data
);

  localparam int              CNT_W    = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  if (COUNT < 2) begin : g_bad_count
    $error("add_accum: COUNT must be at least 2");
  end

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [Y_WIDTH-1:0] acc_r;
  logic [Y_WIDTH-1:0] out_data_r;
  logic [Y_WIDTH-1:0] ext_s;
  logic [Y_WIDTH-1:0] acc_sel_s;
  logic [Y_WIDTH-1:0] sum_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               last_s;

  // The first sample of a frame overwrites the sum, so the adder sees zero
  // instead of the stale accumulator when cnt is 0.
  assign ext_s     = Y_WIDTH'(ext(EXT_W'(in_data), A_WIDTH, (A_SIGNED != 0)));
  assign acc_sel_s = (cnt_r == {CNT_W{1'b0}}) ? {Y_WIDTH{1'b0}} : acc_r;
  assign sum_s     = acc_sel_s + ext_s;
  assign accept_s  = in_valid && in_ready_s;
  assign last_s    = (cnt_r == CNT_LAST);

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == OUT);
  assign out_data  = out_data_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: clear wins; a frame completes on the last accept; a held
  // result leaves once downstream takes it.
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = ACC;
    end else begin
      case (state_r)
        ACC: begin
          if (accept_s && last_s) begin
            state_next_s = OUT;
          end else begin
            state_next_s = ACC;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_next_s = ACC;
          end else begin
            state_next_s = OUT;
          end
        end
        default: state_next_s = ACC;
      endcase
    end
  end

  // Input ready: while a result is held, a sample may enter only in the
  // cycle the result is consumed (combinational from out_ready).
  always_comb begin
    in_ready_s = 1'b0;
    if (clear) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ACC:     in_ready_s = 1'b1;
        OUT:     in_ready_s = out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  // Counter and datapath: accumulate on accept, capture the frame sum on
  // the last sample, abort the partial frame on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {Y_WIDTH{1'b0}};
      out_data_r <= {Y_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r      <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_r <= sum_s;
      if (last_s) begin
        cnt_r      <= {CNT_W{1'b0}};
        out_data_r <= sum_s;
      end else begin
        cnt_r      <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule
